// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives every datapath enable and select from the current state and instruction class.
module mc_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       mem_we,
  output logic [1:0] extop,
  output logic [1:0] alu_op,
  output logic       alu_bsrc,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic [1:0] npc_sel,
  output logic [2:0] state,
  output logic       done,
  output logic       illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [3:0] C_NOP  = 4'd0;
  localparam logic [3:0] C_ADDU = 4'd1;
  localparam logic [3:0] C_SUBU = 4'd2;
  localparam logic [3:0] C_JR   = 4'd3;
  localparam logic [3:0] C_ORI  = 4'd4;
  localparam logic [3:0] C_LUI  = 4'd5;
  localparam logic [3:0] C_LW   = 4'd6;
  localparam logic [3:0] C_SW   = 4'd7;
  localparam logic [3:0] C_BEQ  = 4'd8;
  localparam logic [3:0] C_J    = 4'd9;
  localparam logic [3:0] C_JAL  = 4'd10;
  localparam logic [3:0] C_ILL  = 4'd11;

  logic [2:0] state_q, state_d;
  logic [3:0] class_q, class_d;
  logic [3:0] dec_class;
  logic [3:0] cls;

  logic       pc_we_raw, ir_we_raw, reg_we_raw, mem_we_raw, done_raw, illegal_raw;
  logic [1:0] extop_raw, alu_op_raw, reg_dst_raw, wd_sel_raw, npc_sel_raw;
  logic       alu_bsrc_raw;

  always_comb begin
    dec_class = C_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21:   dec_class = C_ADDU;
          6'h23:   dec_class = C_SUBU;
          6'h08:   dec_class = C_JR;
          6'h00:   dec_class = C_NOP;
          default: dec_class = C_ILL;
        endcase
      end
      6'h0D:   dec_class = C_ORI;
      6'h0F:   dec_class = C_LUI;
      6'h23:   dec_class = C_LW;
      6'h2B:   dec_class = C_SW;
      6'h04:   dec_class = C_BEQ;
      6'h02:   dec_class = C_J;
      6'h03:   dec_class = C_JAL;
      default: dec_class = C_ILL;
    endcase
  end

  // The class is taken live from IR only in DECODE; later states ignore IR.
  assign cls     = (state_q == S_DECODE) ? dec_class : class_q;
  assign class_d = (state_q == S_DECODE) ? dec_class : class_q;

  always_comb begin
    state_d      = S_FETCH;
    pc_we_raw    = 1'b0;
    ir_we_raw    = 1'b0;
    reg_we_raw   = 1'b0;
    mem_we_raw   = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    extop_raw    = 2'd0;
    alu_op_raw   = 2'd0;
    alu_bsrc_raw = 1'b0;
    reg_dst_raw  = 2'd0;
    wd_sel_raw   = 2'd0;
    npc_sel_raw  = 2'd0;

    // ALU/EXT selects are held from EXEC through WB so their outputs stay stable.
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (cls)
        C_SUBU:      alu_op_raw = 2'd1;
        C_ORI:       begin alu_op_raw = 2'd2; alu_bsrc_raw = 1'b1; end
        C_LUI:       begin alu_op_raw = 2'd3; alu_bsrc_raw = 1'b1; end
        C_LW, C_SW:  begin extop_raw  = 2'd1; alu_bsrc_raw = 1'b1; end
        C_BEQ:       begin extop_raw  = 2'd2; alu_op_raw = 2'd1; end
        default:     ;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        ir_we_raw = 1'b1;
        pc_we_raw = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (cls == C_NOP) begin
          done_raw = 1'b1;
          state_d  = S_FETCH;
        end else if (cls == C_ILL) begin
          illegal_raw = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls)
          C_BEQ: begin
            npc_sel_raw = 2'd1;
            pc_we_raw   = zero;
            done_raw    = 1'b1;
            state_d     = S_FETCH;
          end
          C_J: begin
            npc_sel_raw = 2'd2;
            pc_we_raw   = 1'b1;
            done_raw    = 1'b1;
            state_d     = S_FETCH;
          end
          C_JAL: begin
            npc_sel_raw = 2'd2;
            pc_we_raw   = 1'b1;
            reg_we_raw  = 1'b1;
            reg_dst_raw = 2'd2;
            wd_sel_raw  = 2'd2;
            done_raw    = 1'b1;
            state_d     = S_FETCH;
          end
          C_JR: begin
            npc_sel_raw = 2'd3;
            pc_we_raw   = 1'b1;
            done_raw    = 1'b1;
            state_d     = S_FETCH;
          end
          C_LW, C_SW: state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (cls == C_SW) begin
          mem_we_raw = 1'b1;
          done_raw   = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_we_raw  = 1'b1;
        done_raw    = 1'b1;
        reg_dst_raw = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
        wd_sel_raw  = (cls == C_LW) ? 2'd1 : 2'd0;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      class_q <= C_NOP;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
    end
  end

  // Reset is applied combinationally too, so an abort silences the datapath at once.
  assign pc_we    = reset & pc_we_raw;
  assign ir_we    = reset & ir_we_raw;
  assign reg_we   = reset & reg_we_raw;
  assign mem_we   = reset & mem_we_raw;
  assign done     = reset & done_raw;
  assign illegal  = reset & illegal_raw;
  assign extop    = reset ? extop_raw    : 2'd0;
  assign alu_op   = reset ? alu_op_raw   : 2'd0;
  assign alu_bsrc = reset & alu_bsrc_raw;
  assign reg_dst  = reset ? reg_dst_raw  : 2'd0;
  assign wd_sel   = reset ? wd_sel_raw   : 2'd0;
  assign npc_sel  = reset ? npc_sel_raw  : 2'd0;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized self-checking bench for mc_ctrl: each instruction is expanded into an
// expected per-cycle timeline and compared against the DUT at the falling clock edge.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       pc_we, ir_we, reg_we, mem_we, alu_bsrc, done, illegal;
  logic [1:0] extop, alu_op, reg_dst, wd_sel, npc_sel;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
    .extop(extop), .alu_op(alu_op), .alu_bsrc(alu_bsrc), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .npc_sel(npc_sel), .state(state), .done(done), .illegal(illegal)
  );

  typedef enum int {K_NOP, K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW,
                    K_BEQ, K_J, K_JAL, K_ILL} kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we, ir_we, reg_we, mem_we;
    logic [1:0] extop, alu_op;
    logic       bsrc;
    logic [1:0] reg_dst, wd_sel, npc_sel;
    logic       done, illegal;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string tag, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h21) return K_ADDU;
      if (fn == 6'h23) return K_SUBU;
      if (fn == 6'h08) return K_JR;
      if (fn == 6'h00) return K_NOP;
      return K_ILL;
    end
    if (op == 6'h0D) return K_ORI;
    if (op == 6'h0F) return K_LUI;
    if (op == 6'h23) return K_LW;
    if (op == 6'h2B) return K_SW;
    if (op == 6'h04) return K_BEQ;
    if (op == 6'h02) return K_J;
    if (op == 6'h03) return K_JAL;
    return K_ILL;
  endfunction

  // Expected timeline: one entry per cycle from FETCH to the retiring cycle.
  task automatic build_expect(input kind_t k, input logic z);
    exp_t e, alu;
    exp_q.delete();
    alu = '0;
    case (k)
      K_SUBU:      alu.alu_op = 2'd1;
      K_ORI:       begin alu.alu_op = 2'd2; alu.bsrc = 1'b1; end
      K_LUI:       begin alu.alu_op = 2'd3; alu.bsrc = 1'b1; end
      K_LW, K_SW:  begin alu.extop = 2'd1; alu.bsrc = 1'b1; end
      K_BEQ:       begin alu.extop = 2'd2; alu.alu_op = 2'd1; end
      default:     ;
    endcase
    e = '0; e.st = 3'd0; e.ir_we = 1'b1; e.pc_we = 1'b1;
    exp_q.push_back(e);
    e = '0; e.st = 3'd1;
    e.done = (k == K_NOP);
    e.illegal = (k == K_ILL);
    exp_q.push_back(e);
    if (k == K_NOP || k == K_ILL) return;
    e = alu; e.st = 3'd2;
    if (k == K_BEQ) begin e.npc_sel = 2'd1; e.pc_we = z; e.done = 1'b1; end
    if (k == K_J)   begin e.npc_sel = 2'd2; e.pc_we = 1'b1; e.done = 1'b1; end
    if (k == K_JR)  begin e.npc_sel = 2'd3; e.pc_we = 1'b1; e.done = 1'b1; end
    if (k == K_JAL) begin
      e.npc_sel = 2'd2; e.pc_we = 1'b1; e.reg_we = 1'b1;
      e.reg_dst = 2'd2; e.wd_sel = 2'd2; e.done = 1'b1;
    end
    exp_q.push_back(e);
    if (e.done) return;
    if (k == K_LW || k == K_SW) begin
      e = alu; e.st = 3'd3;
      e.mem_we = (k == K_SW);
      e.done = (k == K_SW);
      exp_q.push_back(e);
      if (k == K_SW) return;
    end
    e = alu; e.st = 3'd4; e.reg_we = 1'b1; e.done = 1'b1;
    e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    e.wd_sel  = (k == K_LW) ? 2'd1 : 2'd0;
    exp_q.push_back(e);
  endtask

  task automatic cmp_cycle(input string nm, input exp_t e);
    chk({nm, ".state"},   int'(state),    int'(e.st));
    chk({nm, ".pc_we"},   int'(pc_we),    int'(e.pc_we));
    chk({nm, ".ir_we"},   int'(ir_we),    int'(e.ir_we));
    chk({nm, ".reg_we"},  int'(reg_we),   int'(e.reg_we));
    chk({nm, ".mem_we"},  int'(mem_we),   int'(e.mem_we));
    chk({nm, ".extop"},   int'(extop),    int'(e.extop));
    chk({nm, ".alu_op"},  int'(alu_op),   int'(e.alu_op));
    chk({nm, ".bsrc"},    int'(alu_bsrc), int'(e.bsrc));
    chk({nm, ".reg_dst"}, int'(reg_dst),  int'(e.reg_dst));
    chk({nm, ".wd_sel"},  int'(wd_sel),   int'(e.wd_sel));
    chk({nm, ".npc_sel"}, int'(npc_sel),  int'(e.npc_sel));
    chk({nm, ".done"},    int'(done),     int'(e.done));
    chk({nm, ".illegal"}, int'(illegal),  int'(e.illegal));
    chk({nm, ".excl"},    int'(reg_we & mem_we), 0);
  endtask

  task automatic chk_reset_quiet(input string nm);
    chk({nm, ".state"},   int'(state), 0);
    chk({nm, ".enables"}, int'({pc_we, ir_we, reg_we, mem_we, done, illegal}), 0);
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input bit corrupt, input int abort_at);
    kind_t k;
    string nm;
    opcode = op; funct = fn; zero = z;
    k = classify(op, fn);
    build_expect(k, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      nm = $sformatf("%s[c%0d]", k.name(), i);
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset_quiet({nm, ".abort"});
        @(negedge clk);
        chk_reset_quiet({nm, ".abort_hold"});
        @(posedge clk); #1;
        reset = 1'b1;
        $display("[TB] op=%02h fn=%02h z=%0d aborted at cycle %0d", op, fn, z, i);
        return;
      end
      @(negedge clk);
      cmp_cycle(nm, exp_q[i]);
      @(posedge clk); #1;
      if (i == 1 && corrupt) begin
        opcode = 6'h0D;
        funct  = 6'($urandom);
      end
    end
    $display("[TB] op=%02h fn=%02h z=%0d %s cycles=%0d corrupt=%0d", op, fn, z, k.name(),
             exp_q.size(), corrupt);
  endtask

  logic [5:0] ops_tbl [13] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23,
                               6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F, 6'h00};
  logic [5:0] fns_tbl [13] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h15, 6'h2A, 6'h07,
                               6'h11, 6'h00, 6'h3C, 6'h01, 6'h21, 6'h2A};

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_reset_quiet($sformatf("reset%0d", i));
      chk("reset.selects", int'({extop, alu_op, alu_bsrc, reg_dst, wd_sel, npc_sel}), 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;

    run_instr(6'h00, 6'h21, 1'b0, 1'b0, 99); // addu
    run_instr(6'h23, 6'h05, 1'b0, 1'b0, 99); // lw
    run_instr(6'h2B, 6'h05, 1'b0, 1'b0, 99); // sw
    run_instr(6'h04, 6'h00, 1'b1, 1'b0, 99); // beq taken
    run_instr(6'h04, 6'h00, 1'b0, 1'b0, 99); // beq not taken
    run_instr(6'h03, 6'h00, 1'b0, 1'b0, 99); // jal
    run_instr(6'h00, 6'h08, 1'b0, 1'b0, 99); // jr
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 99); // illegal opcode
    run_instr(6'h00, 6'h2A, 1'b0, 1'b0, 99); // illegal funct
    run_instr(6'h2B, 6'h00, 1'b0, 1'b0, 3);  // sw aborted in MEM
    run_instr(6'h00, 6'h21, 1'b0, 1'b1, 99); // addu, IR becomes ori after DECODE
    run_instr(6'h00, 6'h00, 1'b0, 1'b0, 99); // nop
    run_instr(6'h02, 6'h00, 1'b0, 1'b0, 99); // j
    run_instr(6'h0D, 6'h00, 1'b0, 1'b0, 99); // ori
    run_instr(6'h0F, 6'h00, 1'b0, 1'b0, 99); // lui
    run_instr(6'h00, 6'h23, 1'b0, 1'b0, 99); // subu

    for (int n = 0; n < 300; n++) begin
      int idx;
      logic [5:0] op, fn;
      int abort_at;
      idx = int'($urandom_range(0, 13));
      if (idx == 13) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        op = ops_tbl[idx];
        fn = ops_tbl[idx] == 6'h00 ? fns_tbl[idx] : 6'($urandom);
      end
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 99;
      run_instr(op, fn, 1'($urandom), ($urandom_range(0, 3) == 0), abort_at);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
